// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns symbolic fields into 32-bit words and
// streams them into instruction memory at an auto-incrementing address.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [3:0] {
        OP_SLL  = 4'd0,  OP_SRL = 4'd1,  OP_SRA = 4'd2,  OP_ORI = 4'd3,
        OP_AND  = 4'd4,  OP_OR  = 4'd5,  OP_ADD = 4'd6,  OP_SLTI = 4'd7,
        OP_SLT  = 4'd8,  OP_J   = 4'd9,  OP_BEQ = 4'd10, OP_BNE = 4'd11,
        OP_LUI  = 4'd12, OP_SW  = 4'd13, OP_LW  = 4'd14, OP_ILL = 4'd15
    } op_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
    } req_t;

    req_t              req;
    op_e               op;
    logic [31:0]       enc;
    logic              legal;
    logic              accept;
    logic              acc_wr;
    logic              acc_ill;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    assign req   = '{rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                     imm: in_imm, target: in_target};
    assign op    = op_e'(in_op);
    assign legal = (op != OP_ILL);

    // Shifts zero rs and non-shift R-types zero shamt so the decoder sees
    // canonical words regardless of what the loader left in unused fields.
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    always_comb begin
        enc = 32'h0;
        case (op)
            OP_SLL:  enc = rtype(5'd0,   req.rt, req.rd, req.shamt, 6'b000000);
            OP_SRL:  enc = rtype(5'd0,   req.rt, req.rd, req.shamt, 6'b000010);
            OP_SRA:  enc = rtype(5'd0,   req.rt, req.rd, req.shamt, 6'b000011);
            OP_AND:  enc = rtype(req.rs, req.rt, req.rd, 5'd0,      6'b100100);
            OP_OR:   enc = rtype(req.rs, req.rt, req.rd, 5'd0,      6'b100101);
            OP_ADD:  enc = rtype(req.rs, req.rt, req.rd, 5'd0,      6'b100000);
            OP_SLT:  enc = rtype(req.rs, req.rt, req.rd, 5'd0,      6'b101010);
            OP_ORI:  enc = itype(6'b001101, req.rs, req.rt, req.imm);
            OP_SLTI: enc = itype(6'b001010, req.rs, req.rt, req.imm);
            OP_BEQ:  enc = itype(6'b000100, req.rs, req.rt, req.imm);
            OP_BNE:  enc = itype(6'b000101, req.rs, req.rt, req.imm);
            OP_LUI:  enc = itype(6'b001111, 5'd0,   req.rt, req.imm);
            OP_SW:   enc = itype(6'b101011, req.rs, req.rt, req.imm);
            OP_LW:   enc = itype(6'b100011, req.rs, req.rt, req.imm);
            OP_J:    enc = {6'b000010, req.target};
            default: enc = 32'h0;
        endcase
    end

    assign full     = (cnt == DEPTH_C);
    assign in_ready = !rst && !clear && !full;
    assign accept   = in_valid && in_ready;
    assign acc_wr   = accept && legal;
    assign acc_ill  = accept && !legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= BASE_C;
            cnt     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= 32'h0;
        end else begin
            we_q  <= acc_wr;
            err_q <= acc_ill;
            if (acc_wr) begin
                addr_q  <= ptr;
                wdata_q <= enc;
            end
            // accept is blocked while clear is high, so the two never collide
            if (clear) begin
                ptr <= BASE_C;
                cnt <= '0;
            end else if (acc_wr) begin
                ptr <= ptr + 1'b1;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A strobe staged before a reset must not reach memory in the reset cycle.
    assign im_we       = we_q && !rst;
    assign err_illegal = err_q && !rst;
    assign im_addr     = addr_q;
    assign im_wdata    = wdata_q;
    assign word_count  = cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, full/clear/reset edges.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, im_we, full, err_illegal;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic [8:0]  word_count;

    logic        s_in_ready, s_im_we, s_full, s_err_illegal;
    logic [1:0]  s_im_addr;
    logic [31:0] s_im_wdata;
    logic [2:0]  s_word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .word_count(word_count), .full(full), .err_illegal(err_illegal)
    );

    // Small instance: 4-word memory starting at 2 so the address wraps mod 4.
    instr_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(2)) u_small (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .im_we(s_im_we), .im_addr(s_im_addr),
        .im_wdata(s_im_wdata), .word_count(s_word_count), .full(s_full),
        .err_illegal(s_err_illegal)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] tgt);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tgt;
    endtask

    task automatic add3();
        drive(4'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int nw;
        logic [1:0] sa;
        vecs[0]  = '{4'd14, 5'd29, 5'd8,  5'd0,  5'd0,  16'h0004, 26'h0,  32'h8FA80004}; // LW
        vecs[1]  = '{4'd0,  5'd9,  5'd1,  5'd2,  5'd4,  16'h0,    26'h0,  32'h00011100}; // SLL rs forced 0
        vecs[2]  = '{4'd10, 5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF, 26'h0,  32'h1022FFFF}; // BEQ
        vecs[3]  = '{4'd9,  5'd3,  5'd3,  5'd3,  5'd3,  16'h0,    26'h10, 32'h08000010}; // J
        vecs[4]  = '{4'd12, 5'd7,  5'd1,  5'd0,  5'd0,  16'h1234, 26'h0,  32'h3C011234}; // LUI rs forced 0
        vecs[5]  = '{4'd1,  5'd7,  5'd6,  5'd5,  5'd31, 16'h0,    26'h0,  32'h00062FC2}; // SRL
        vecs[6]  = '{4'd2,  5'd31, 5'd2,  5'd1,  5'd1,  16'h0,    26'h0,  32'h00020843}; // SRA
        vecs[7]  = '{4'd4,  5'd10, 5'd11, 5'd9,  5'd5,  16'h0,    26'h0,  32'h014B4824}; // AND shamt forced 0
        vecs[8]  = '{4'd5,  5'd31, 5'd31, 5'd31, 5'd0,  16'h0,    26'h0,  32'h03FFF825}; // OR
        vecs[9]  = '{4'd8,  5'd2,  5'd3,  5'd1,  5'd0,  16'h0,    26'h0,  32'h0043082A}; // SLT
        vecs[10] = '{4'd3,  5'd1,  5'd2,  5'd0,  5'd0,  16'h00FF, 26'h0,  32'h342200FF}; // ORI
        vecs[11] = '{4'd7,  5'd4,  5'd5,  5'd0,  5'd0,  16'h8000, 26'h0,  32'h28858000}; // SLTI
        vecs[12] = '{4'd11, 5'd3,  5'd0,  5'd0,  5'd0,  16'h0002, 26'h0,  32'h14600002}; // BNE
        vecs[13] = '{4'd13, 5'd29, 5'd31, 5'd0,  5'd0,  16'h0008, 26'h0,  32'hAFBF0008}; // SW

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
        tick(); tick();
        chk("rst_we", im_we, 0);
        chk("rst_addr", im_addr, 0);
        chk("rst_wdata", im_wdata, 0);
        chk("rst_count", word_count, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_small_addr", s_im_addr, 2);

        // single ADD
        rst = 1'b0; add3(); #1;
        chk("add_ready", in_ready, 1);
        tick(); idle();
        chk("add_we", im_we, 1);
        chk("add_addr", im_addr, 0);
        chk("add_wdata", im_wdata, 32'h00221820);
        chk("add_count", word_count, 1);
        tick();
        chk("add_we_drop", im_we, 0);
        chk("add_wdata_hold", im_wdata, 32'h00221820);

        // back-to-back stream over every legal op
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
            tick();
            chk($sformatf("stream_we%0d", i), im_we, 1);
            chk($sformatf("stream_addr%0d", i), im_addr, i);
            chk($sformatf("stream_word%0d", i), im_wdata, vecs[i].exp);
        end
        idle(); tick();
        chk("stream_we_end", im_we, 0);
        chk("stream_count", word_count, 14);

        // illegal op between two ADDs
        do_reset();
        add3(); tick();
        chk("ill_add0_addr", im_addr, 0);
        chk("ill_err0", err_illegal, 0);
        drive(4'd15, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0); tick();
        chk("ill_we", im_we, 0);
        chk("ill_err", err_illegal, 1);
        chk("ill_count", word_count, 1);
        drive(4'd6, 5'd1, 5'd2, 5'd4, 5'd0, 16'h0, 26'h0); tick();
        chk("ill_err_pulse", err_illegal, 0);
        chk("ill_add1_we", im_we, 1);
        chk("ill_add1_addr", im_addr, 1);
        chk("ill_add1_word", im_wdata, 32'h00222020);
        idle(); tick();
        chk("ill_final_count", word_count, 2);

        // small instance fills after 4 of 6 presented ops; addresses wrap 2,3,0,1
        do_reset();
        nw = 0; sa = 2'd2;
        for (int i = 0; i < 6; i++) begin
            add3(); tick();
            if (s_im_we) begin
                chk($sformatf("full_addr%0d", nw), s_im_addr, sa);
                sa = sa + 2'd1;
                nw++;
            end
        end
        idle(); tick();
        if (s_im_we) nw++;
        chk("full_writes", nw, 4);
        chk("full_flag", s_full, 1);
        chk("full_count", s_word_count, 4);
        add3(); #1;
        chk("full_ready", s_in_ready, 0);
        idle();
        clear = 1'b1; tick(); clear = 1'b0; #1;
        chk("clr_full", s_full, 0);
        chk("clr_count", s_word_count, 0);
        chk("clr_ready", s_in_ready, 1);
        add3(); tick(); idle();
        chk("clr_we", s_im_we, 1);
        chk("clr_addr", s_im_addr, 2);

        // clear with in_valid: staged write still lands, no new accept
        do_reset();
        add3(); tick();
        clear = 1'b1; drive(4'd6, 5'd1, 5'd2, 5'd5, 5'd0, 16'h0, 26'h0); #1;
        chk("clrv_ready", in_ready, 0);
        chk("clrv_staged_we", im_we, 1);
        chk("clrv_staged_addr", im_addr, 0);
        tick(); clear = 1'b0; idle();
        chk("clrv_no_accept", im_we, 0);
        chk("clrv_count", word_count, 0);
        add3(); tick(); idle();
        chk("clrv_next_we", im_we, 1);
        chk("clrv_next_addr", im_addr, 0);

        // reset right after an accept suppresses the strobe
        do_reset();
        add3(); tick();
        drive(4'd6, 5'd1, 5'd2, 5'd7, 5'd0, 16'h0, 26'h0); tick();
        rst = 1'b1; idle(); #1;
        chk("rstm_we_gated", im_we, 0);
        tick();
        chk("rstm_we", im_we, 0);
        chk("rstm_addr", im_addr, 0);
        chk("rstm_wdata", im_wdata, 0);
        chk("rstm_count", word_count, 0);
        rst = 1'b0; add3(); tick(); idle();
        chk("rstm_first_we", im_we, 1);
        chk("rstm_first_addr", im_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
